alu_op_sequencer: RTL

Hardwired micro-sequencer that runs one ALU instruction through the Datapath. It accepts a start request and a 32-bit instruction word, then drives the Datapath control inputs in fixed T-states until writeback completes. It generalises the original single-SUB T0–T4 sequence in three ways: any register ALU op, immediate-operand ops, and two-result ops (MUL/DIV) that write both the low and the high result. It sits between the fetch/issue logic and the Datapath, replacing hand-driven control.

---
 rtl/alu_seq_pkg.sv | 69 ++++++
 rtl/alu_op_sequencer_if.sv | 38 +++
 rtl/alu_seq_decode.sv | 31 +++
 rtl/alu_op_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: widths, opcodes, ALU codes,
// state encoding, instruction classes and the immediate sign-extender.
package alu_seq_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int IMM_W  = 19;

  localparam logic [REG_AW-1:0] LO_ADDR = 4'd14;
  localparam logic [REG_AW-1:0] HI_ADDR = 4'd15;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_ROR  = 5'd6;
  localparam logic [4:0] OP_ROL  = 5'd7;
  localparam logic [4:0] OP_ADDI = 5'd8;
  localparam logic [4:0] OP_ANDI = 5'd9;
  localparam logic [4:0] OP_ORI  = 5'd10;
  localparam logic [4:0] OP_MUL  = 5'd11;
  localparam logic [4:0] OP_DIV  = 5'd12;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SHR = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_ROR = 4'd7;
  localparam logic [3:0] ALU_ROL = 4'd8;
  localparam logic [3:0] ALU_MUL = 4'd9;
  localparam logic [3:0] ALU_DIV = 4'd10;

  // Bit positions inside the 6-bit {BIS, RZHS, WBM, WBP, MAP, ASS} mux select
  localparam int MUX_BIS  = 5;
  localparam int MUX_RZHS = 4;
  localparam int MUX_WBM  = 3;
  localparam int MUX_WBP  = 2;
  localparam int MUX_MAP  = 1;
  localparam int MUX_ASS  = 0;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_WBL    = 4'd4,
    ST_WRL    = 4'd5,
    ST_WBH    = 4'd6,
    ST_WRH    = 4'd7,
    ST_DONE   = 4'd8
  } seq_state_t;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_I   = 2'd1,
    CLS_W   = 2'd2,
    CLS_ILL = 2'd3
  } instr_class_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Issue-side request and Datapath control bundle of the ALU op sequencer.
interface alu_op_sequencer_if;
  import alu_seq_pkg::*;

  logic              iStart;
  logic [31:0]       iInstr;
  logic              oBusy;
  logic              oDone;
  logic              oErr;
  logic              oPC_en;
  logic [REG_AW-1:0] oRF_AddrA;
  logic [REG_AW-1:0] oRF_AddrB;
  logic [REG_AW-1:0] oRF_AddrC;
  logic              oRF_Write;
  logic              oRA_en;
  logic              oRB_en;
  logic              oRZH_en;
  logic              oRZL_en;
  logic              oRWB_en;
  logic [3:0]        oALU_Ctrl;
  logic [DATA_W-1:0] oImm32;
  logic [5:0]        oMuxSel;

  modport master (
    input  iStart, iInstr,
    output oBusy, oDone, oErr, oPC_en, oRF_AddrA, oRF_AddrB, oRF_AddrC,
           oRF_Write, oRA_en, oRB_en, oRZH_en, oRZL_en, oRWB_en,
           oALU_Ctrl, oImm32, oMuxSel
  );

  modport slave (
    output iStart, iInstr,
    input  oBusy, oDone, oErr, oPC_en, oRF_AddrA, oRF_AddrB, oRF_AddrC,
           oRF_Write, oRA_en, oRB_en, oRZH_en, oRZL_en, oRWB_en,
           oALU_Ctrl, oImm32, oMuxSel
  );

endinterface

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder: instruction class and ALU operation code.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t instr_class,
  output logic [3:0]   alu_ctrl
);

  always_comb begin
    instr_class = CLS_ILL;
    alu_ctrl    = ALU_NOP;
    case (opcode)
      OP_ADD:  begin instr_class = CLS_R; alu_ctrl = ALU_ADD; end
      OP_SUB:  begin instr_class = CLS_R; alu_ctrl = ALU_SUB; end
      OP_AND:  begin instr_class = CLS_R; alu_ctrl = ALU_AND; end
      OP_OR:   begin instr_class = CLS_R; alu_ctrl = ALU_OR;  end
      OP_SHR:  begin instr_class = CLS_R; alu_ctrl = ALU_SHR; end
      OP_SHL:  begin instr_class = CLS_R; alu_ctrl = ALU_SHL; end
      OP_ROR:  begin instr_class = CLS_R; alu_ctrl = ALU_ROR; end
      OP_ROL:  begin instr_class = CLS_R; alu_ctrl = ALU_ROL; end
      OP_ADDI: begin instr_class = CLS_I; alu_ctrl = ALU_ADD; end
      OP_ANDI: begin instr_class = CLS_I; alu_ctrl = ALU_AND; end
      OP_ORI:  begin instr_class = CLS_I; alu_ctrl = ALU_OR;  end
      OP_MUL:  begin instr_class = CLS_W; alu_ctrl = ALU_MUL; end
      OP_DIV:  begin instr_class = CLS_W; alu_ctrl = ALU_DIV; end
      default: begin instr_class = CLS_ILL; alu_ctrl = ALU_NOP; end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Hardwired T-state sequencer driving the Datapath for one ALU instruction
// (register, immediate and two-result ops). All outputs are registered.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input logic                 iClk,
  input logic                 nRst,
  alu_op_sequencer_if.master  bus
);

  seq_state_t        state_reg, state_next;
  logic [31:0]       instr_reg, instr_next;
  instr_class_t      instr_class;
  logic [3:0]        alu_ctrl;

  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              pc_en_reg, pc_en_next;
  logic [REG_AW-1:0] addr_a_reg, addr_a_next;
  logic [REG_AW-1:0] addr_b_reg, addr_b_next;
  logic [REG_AW-1:0] addr_c_reg, addr_c_next;
  logic              rf_write_reg, rf_write_next;
  logic              ra_en_reg, ra_en_next;
  logic              rb_en_reg, rb_en_next;
  logic              rzh_en_reg, rzh_en_next;
  logic              rzl_en_reg, rzl_en_next;
  logic              rwb_en_reg, rwb_en_next;
  logic [3:0]        alu_ctrl_reg, alu_ctrl_next;
  logic [DATA_W-1:0] imm32_reg, imm32_next;
  logic [5:0]        mux_sel_reg, mux_sel_next;

  // Outputs are registered from the upcoming state, so the instruction word
  // being latched at the end of FETCH is already the one decoded here.
  assign instr_next = (state_reg == ST_FETCH) ? bus.iInstr : instr_reg;

  alu_seq_decode u_decode (
    .opcode      (instr_next[31:27]),
    .instr_class (instr_class),
    .alu_ctrl    (alu_ctrl)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.iStart) state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   state_next = (instr_class == CLS_ILL) ? ST_DONE : ST_WBL;
      ST_WBL:    state_next = ST_WRL;
      ST_WRL:    state_next = (instr_class == CLS_W) ? ST_WBH : ST_DONE;
      ST_WBH:    state_next = ST_WRH;
      ST_WRH:    state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_next     = (state_next != ST_IDLE);
    done_next     = 1'b0;
    err_next      = 1'b0;
    pc_en_next    = 1'b0;
    addr_a_next   = '0;
    addr_b_next   = '0;
    addr_c_next   = '0;
    rf_write_next = 1'b0;
    ra_en_next    = 1'b0;
    rb_en_next    = 1'b0;
    rzh_en_next   = 1'b0;
    rzl_en_next   = 1'b0;
    rwb_en_next   = 1'b0;
    alu_ctrl_next = '0;
    imm32_next    = '0;
    mux_sel_next  = '0;

    // Operand addresses, ALU code and immediate stay put from DECODE to DONE
    if (state_next != ST_IDLE && state_next != ST_FETCH) begin
      addr_a_next   = instr_next[22:19];
      addr_b_next   = instr_next[18:15];
      alu_ctrl_next = alu_ctrl;
      imm32_next    = sext_imm(instr_next[IMM_W-1:0]);
    end

    case (state_next)
      ST_FETCH: begin
        pc_en_next            = 1'b1;
        mux_sel_next[MUX_MAP] = 1'b1;
      end
      ST_DECODE: begin
        ra_en_next            = 1'b1;
        rb_en_next            = 1'b1;
        mux_sel_next[MUX_BIS] = (instr_class == CLS_I);
      end
      ST_EXEC: begin
        rzh_en_next = 1'b1;
        rzl_en_next = 1'b1;
      end
      ST_WBL: begin
        rwb_en_next = 1'b1;
      end
      ST_WRL: begin
        addr_c_next   = (instr_class == CLS_W) ? LO_ADDR : instr_next[26:23];
        rf_write_next = 1'b1;
      end
      ST_WBH: begin
        mux_sel_next[MUX_RZHS] = 1'b1;
        rwb_en_next            = 1'b1;
      end
      ST_WRH: begin
        addr_c_next   = HI_ADDR;
        rf_write_next = 1'b1;
      end
      ST_DONE: begin
        done_next = 1'b1;
        err_next  = (instr_class == CLS_ILL);
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_reg    <= ST_IDLE;
      instr_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      pc_en_reg    <= 1'b0;
      addr_a_reg   <= '0;
      addr_b_reg   <= '0;
      addr_c_reg   <= '0;
      rf_write_reg <= 1'b0;
      ra_en_reg    <= 1'b0;
      rb_en_reg    <= 1'b0;
      rzh_en_reg   <= 1'b0;
      rzl_en_reg   <= 1'b0;
      rwb_en_reg   <= 1'b0;
      alu_ctrl_reg <= '0;
      imm32_reg    <= '0;
      mux_sel_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      instr_reg    <= instr_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      pc_en_reg    <= pc_en_next;
      addr_a_reg   <= addr_a_next;
      addr_b_reg   <= addr_b_next;
      addr_c_reg   <= addr_c_next;
      rf_write_reg <= rf_write_next;
      ra_en_reg    <= ra_en_next;
      rb_en_reg    <= rb_en_next;
      rzh_en_reg   <= rzh_en_next;
      rzl_en_reg   <= rzl_en_next;
      rwb_en_reg   <= rwb_en_next;
      alu_ctrl_reg <= alu_ctrl_next;
      imm32_reg    <= imm32_next;
      mux_sel_reg  <= mux_sel_next;
    end
  end

  assign bus.oBusy     = busy_reg;
  assign bus.oDone     = done_reg;
  assign bus.oErr      = err_reg;
  assign bus.oPC_en    = pc_en_reg;
  assign bus.oRF_AddrA = addr_a_reg;
  assign bus.oRF_AddrB = addr_b_reg;
  assign bus.oRF_AddrC = addr_c_reg;
  assign bus.oRF_Write = rf_write_reg;
  assign bus.oRA_en    = ra_en_reg;
  assign bus.oRB_en    = rb_en_reg;
  assign bus.oRZH_en   = rzh_en_reg;
  assign bus.oRZL_en   = rzl_en_reg;
  assign bus.oRWB_en   = rwb_en_reg;
  assign bus.oALU_Ctrl = alu_ctrl_reg;
  assign bus.oImm32    = imm32_reg;
  assign bus.oMuxSel   = mux_sel_reg;

endmodule
